// File: rtl/nibble_sort_stream_if.sv
// Stream interface for the streaming nibble sorter.
// Carries the input handshake (in_valid/in_ready/in_data), the output handshake
// (out_valid/out_ready/out_data/out_idx/out_last) and the busy status flag.
//   master : producer/consumer side (drives in_*, out_ready; observes the rest)
//   slave  : sorter side (drives in_ready, out_*, busy; observes the rest)
interface nibble_sort_stream_if #(
    parameter int W = 4,
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );
endinterface

// File: rtl/nibble_sort_stream.sv
// Streaming insertion sorter.
// Accepts N unsigned W-bit values one per input handshake, keeping them in a
// descending array (stable for ties), then returns them one per output handshake,
// largest first, each tagged with its arrival index within the batch.
// Ports:
//   clk   : rising-edge clock
//   nrst  : asynchronous active-low reset
//   bus   : slave side of nibble_sort_stream_if (input/output handshakes, busy)
// All interface outputs come straight from flops; their next values are derived
// from the next-state datapath so timing matches a purely state-decoded output.
module nibble_sort_stream #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    nibble_sort_stream_if.slave   bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [0:0] {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_s;

    logic [W-1:0]  arr_val_r [N];
    logic [IW-1:0] arr_idx_r [N];
    logic [W-1:0]  arr_val_s [N];
    logic [IW-1:0] arr_idx_s [N];
    logic [W-1:0]  sh_val_s  [N];
    logic [IW-1:0] sh_idx_s  [N];

    logic [IW-1:0] cnt_r;
    logic [IW-1:0] cnt_s;
    logic [IW-1:0] rd_r;
    logic [IW-1:0] rd_s;

    logic          in_fire_s;
    logic          out_fire_s;
    int            ins_pos_s;

    logic          in_ready_r;
    logic          out_valid_r;
    logic [W-1:0]  out_data_r;
    logic [IW-1:0] out_idx_r;
    logic          out_last_r;
    logic          busy_r;
    logic          in_ready_s;
    logic          out_valid_s;
    logic [W-1:0]  out_data_s;
    logic [IW-1:0] out_idx_s;
    logic          out_last_s;
    logic          busy_s;

    // Handshake qualification: input only counts in LOAD, output only in DRAIN.
    always_comb begin
        in_fire_s  = (state_r == ST_LOAD)  && bus.in_valid;
        out_fire_s = (state_r == ST_DRAIN) && bus.out_ready;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic: full batch -> DRAIN, last output -> LOAD.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (in_fire_s && (cnt_r == LAST_IDX)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (out_fire_s && (rd_r == LAST_IDX)) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_LOAD;
            end
        endcase
    end

    // Insertion point: lowest occupied slot whose value is strictly smaller than
    // the newcomer; strict compare places a tie after existing equals (stable).
    always_comb begin
        ins_pos_s = int'(cnt_r);
        for (int i = N - 1; i >= 0; i--) begin
            ins_pos_s = ((i < int'(cnt_r)) && (arr_val_r[i] < bus.in_data)) ? i : ins_pos_s;
        end
    end

    // Array shifted down by one slot, used for entries below the insertion point.
    always_comb begin
        sh_val_s[0] = arr_val_r[0];
        sh_idx_s[0] = arr_idx_r[0];
        for (int i = 1; i < N; i++) begin
            sh_val_s[i] = arr_val_r[i-1];
            sh_idx_s[i] = arr_idx_r[i-1];
        end
    end

    // Next array contents and counters.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            arr_val_s[i] = arr_val_r[i];
            arr_idx_s[i] = arr_idx_r[i];
            if (in_fire_s && (i == ins_pos_s)) begin
                arr_val_s[i] = bus.in_data;
                arr_idx_s[i] = cnt_r;
            end else if (in_fire_s && (i > ins_pos_s) && (i <= int'(cnt_r))) begin
                arr_val_s[i] = sh_val_s[i];
                arr_idx_s[i] = sh_idx_s[i];
            end else begin
                arr_val_s[i] = arr_val_r[i];
                arr_idx_s[i] = arr_idx_r[i];
            end
        end

        if (in_fire_s) begin
            cnt_s = (cnt_r == LAST_IDX) ? {IW{1'b0}} : (cnt_r + IW'(1));
        end else begin
            cnt_s = cnt_r;
        end

        if (out_fire_s) begin
            rd_s = (rd_r == LAST_IDX) ? {IW{1'b0}} : (rd_r + IW'(1));
        end else begin
            rd_s = rd_r;
        end
    end

    // Datapath registers: sorted array plus fill and read pointers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < N; i++) begin
                arr_val_r[i] <= {W{1'b0}};
                arr_idx_r[i] <= {IW{1'b0}};
            end
            cnt_r <= {IW{1'b0}};
            rd_r  <= {IW{1'b0}};
        end else begin
            for (int i = 0; i < N; i++) begin
                arr_val_r[i] <= arr_val_s[i];
                arr_idx_r[i] <= arr_idx_s[i];
            end
            cnt_r <= cnt_s;
            rd_r  <= rd_s;
        end
    end

    // FSM output logic: next values of the registered interface outputs.
    always_comb begin
        in_ready_s  = (state_s == ST_LOAD);
        out_valid_s = (state_s == ST_DRAIN);
        busy_s      = (cnt_s != {IW{1'b0}}) || (state_s == ST_DRAIN);
        if (state_s == ST_DRAIN) begin
            out_data_s = arr_val_s[rd_s];
            out_idx_s  = arr_idx_s[rd_s];
            out_last_s = (rd_s == LAST_IDX);
        end else begin
            out_data_s = {W{1'b0}};
            out_idx_s  = {IW{1'b0}};
            out_last_s = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
            out_idx_r   <= {IW{1'b0}};
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_idx_r   <= out_idx_s;
            out_last_r  <= out_last_s;
            busy_r      <= busy_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_nibble_sort_stream.sv
// Self-checking bench for nibble_sort_stream (W=4, N=4).
// Directed table vectors, stall / back-to-back / reset sequences, and random
// batches compared against a value-scan sorting model.
module tb_nibble_sort_stream;
    localparam int W = 4;
    localparam int N = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    nibble_sort_stream_if #(.W(W), .N(N)) bus ();

    nibble_sort_stream #(.W(W), .N(N)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [15:0] din;   // arrival k in din[4k+:4]
        logic [15:0] ev;    // k-th output value in ev[4k+:4]
        logic [7:0]  ei;    // k-th output index in ei[2k+:2]
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: scan values from largest to smallest, arrivals in order, so
    // equal values come out in arrival order.
    task automatic model(input logic [15:0] din, output logic [15:0] ev, output logic [7:0] ei);
        int k;
        k = 0;
        ev = 16'h0000;
        ei = 8'h00;
        for (int v = 15; v >= 0; v--) begin
            for (int j = 0; j < 4; j++) begin
                if (int'(din[4*j +: 4]) == v) begin
                    ev[4*k +: 4] = din[4*j +: 4];
                    ei[2*k +: 2] = 2'(j);
                    k++;
                end
            end
        end
    endtask

    // Feed one batch; gaps inserts random idle cycles on in_valid.
    task automatic send_batch(input logic [15:0] din, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            bit acc;
            bit v;
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                check("empty_no_valid", 32'(bus.out_valid), 32'd0);
                v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.in_valid = v;
                bus.in_data  = din[4*k +: 4];
                if (v && bus.in_ready) acc = 1'b1;
            end
            if (!acc) check("send_timeout", 32'd0, 32'd1);
        end
    endtask

    // Drain one batch. mode 0: always ready, 1: pattern bit per cycle, 2: random.
    task automatic recv_batch(input logic [15:0] ev, input logic [7:0] ei, input int mode,
                              input logic [7:0] pattern, input bit drive_in);
        int  got;
        int  cyc;
        bit  r;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 200) begin
            @(negedge clk);
            bus.in_valid = drive_in;
            bus.in_data  = 4'($urandom);
            if (cyc == 0) check("first_valid_latency", 32'(bus.out_valid), 32'd1);
            check("drain_in_ready", 32'(bus.in_ready), 32'd0);
            check("drain_valid", 32'(bus.out_valid), 32'd1);
            check("drain_busy", 32'(bus.busy), 32'd1);
            check("out_data", 32'(bus.out_data), 32'(ev[4*got +: 4]));
            check("out_idx", 32'(bus.out_idx), 32'(ei[2*got +: 2]));
            check("out_last", 32'(bus.out_last), (got == 3) ? 32'd1 : 32'd0);
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = pattern[cyc % 8];
            else                r = 1'($urandom);
            bus.out_ready = r;
            if (bus.out_valid && r) got++;
            cyc++;
        end
        if (got < 4) check("recv_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("post_valid", 32'(bus.out_valid), 32'd0);
        check("post_busy", 32'(bus.busy), 32'd0);
        check("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] mev;
        logic [7:0]  mei;
        logic [15:0] din;
        logic [3:0]  bv [8];
        logic [3:0]  xv [8];
        logic [1:0]  xi [8];
        int          sent;
        int          recv;
        int          first0;
        int          first1;
        int          acc5;
        int          last0;

        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.out_ready = 1'b0;

        vecs[0] = '{din: {4'h7, 4'h1, 4'h9, 4'h3}, ev: {4'h1, 4'h3, 4'h7, 4'h9}, ei: {2'd2, 2'd0, 2'd3, 2'd1}};
        vecs[1] = '{din: {4'h5, 4'h2, 4'h5, 4'h5}, ev: {4'h2, 4'h5, 4'h5, 4'h5}, ei: {2'd2, 2'd3, 2'd1, 2'd0}};
        vecs[2] = '{din: {4'h0, 4'hF, 4'h0, 4'hF}, ev: {4'h0, 4'h0, 4'hF, 4'hF}, ei: {2'd3, 2'd1, 2'd2, 2'd0}};
        vecs[3] = '{din: {4'h4, 4'h3, 4'h2, 4'h1}, ev: {4'h1, 4'h2, 4'h3, 4'h4}, ei: {2'd0, 2'd1, 2'd2, 2'd3}};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_idx", 32'(bus.out_idx), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        nrst = 1'b1;

        // Directed table
        for (int i = 0; i < 4; i++) begin
            send_batch(vecs[i].din, 1'b0);
            recv_batch(vecs[i].ev, vecs[i].ei, 0, 8'h00, 1'b0);
        end

        // Stall pattern 0,1,0,0,1,1,0,1 with in_valid held high during drain
        send_batch({4'h6, 4'h2, 4'h8, 4'h4}, 1'b0);
        recv_batch({4'h2, 4'h4, 4'h6, 4'h8}, {2'd2, 2'd0, 2'd3, 2'd1}, 1, 8'b1011_0010, 1'b1);

        // Back-to-back batches with in_valid and out_ready always high
        din = {4'h5, 4'h2, 4'h5, 4'h5};
        for (int k = 0; k < 4; k++) bv[k] = din[4*k +: 4];
        model(din, mev, mei);
        for (int k = 0; k < 4; k++) begin
            xv[k] = mev[4*k +: 4];
            xi[k] = mei[2*k +: 2];
        end
        din = 16'($urandom);
        for (int k = 0; k < 4; k++) bv[k+4] = din[4*k +: 4];
        model(din, mev, mei);
        for (int k = 0; k < 4; k++) begin
            xv[k+4] = mev[4*k +: 4];
            xi[k+4] = mei[2*k +: 2];
        end
        sent = 0; recv = 0; first0 = -1; first1 = -1; acc5 = -1; last0 = -1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 60 && recv < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (recv == 0) first0 = c;
                if (recv == 4) first1 = c;
                if (recv == 3) last0 = c;
                check("b2b_data", 32'(bus.out_data), 32'(xv[recv]));
                check("b2b_idx", 32'(bus.out_idx), 32'(xi[recv]));
                check("b2b_last", 32'(bus.out_last), (recv % 4 == 3) ? 32'd1 : 32'd0);
                recv++;
            end
            bus.in_valid = (sent < 8);
            bus.in_data  = (sent < 8) ? bv[sent] : 4'h0;
            if (bus.in_ready && sent < 8) begin
                if (sent == 4) acc5 = c;
                sent++;
            end
        end
        check("b2b_count", 32'(recv), 32'd8);
        check("b2b_latency", 32'(first0), 32'd4);
        check("b2b_period", 32'(first1 - first0), 32'd8);
        check("b2b_restart", 32'(acc5 - last0), 32'd1);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_idle_busy", 32'(bus.busy), 32'd0);

        // Reset mid-LOAD
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(k + 7);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("partial_busy", 32'(bus.busy), 32'd1);
        #1 nrst = 1'b0;
        #1;
        check("rstload_busy", 32'(bus.busy), 32'd0);
        check("rstload_in_ready", 32'(bus.in_ready), 32'd1);
        check("rstload_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        // Reset mid-DRAIN after one output handshake
        send_batch({4'h9, 4'hA, 4'hB, 4'hC}, 1'b0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("mid_drain_data", 32'(bus.out_data), 32'hB);
        #1 nrst = 1'b0;
        #1;
        check("rstdrain_valid", 32'(bus.out_valid), 32'd0);
        check("rstdrain_data", 32'(bus.out_data), 32'd0);
        check("rstdrain_idx", 32'(bus.out_idx), 32'd0);
        check("rstdrain_last", 32'(bus.out_last), 32'd0);
        check("rstdrain_busy", 32'(bus.busy), 32'd0);
        check("rstdrain_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        nrst = 1'b1;
        send_batch(vecs[3].din, 1'b0);
        recv_batch(vecs[3].ev, vecs[3].ei, 0, 8'h00, 1'b0);

        // Random batches against the model, random gaps and backpressure
        for (int b = 0; b < 30; b++) begin
            din = 16'($urandom);
            if (b % 5 == 0) din[7:0] = din[15:8];
            model(din, mev, mei);
            send_batch(din, 1'b1);
            recv_batch(mev, mei, 2, 8'h00, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
